// File: rtl/knn_voter.sv
// +---------------------------------------------------------------------------+
// | knn_voter: walks the sorter's K nearest slots, fetches class labels,      |
// | counts votes per class and reports the argmax with a one-cycle done.      |
// | Optional feature macro: KNN_VOTER_NEAREST_TIE_EN (nearest-rank tie break).|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module knn_voter #(
  parameter int W      = 32,
  parameter int HW_K   = 10,
  parameter int NCLASS = 10,
  parameter int LBL_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [W/2-1:0]               k_i,
  output logic [W/2-1:0]               sel_o,
  input  logic [W/2-1:0]               idx_in_i,
  output logic [W/2-1:0]               lbl_addr_o,
  output logic                         lbl_rd_o,
  input  logic [LBL_W-1:0]             lbl_data_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [LBL_W-1:0]             label_o,
  output logic [$clog2(HW_K+1)-1:0]    votes_o,
  output logic                         lbl_err_o
);

  localparam int SW = W / 2;
  localparam int CW = $clog2(HW_K + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_ARGMAX = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      kk_q, s_q;
  logic               rd_q;
  logic [CW-1:0]      cnt_q [NCLASS];
  logic [LBL_W-1:0]   c_q, best_q, best_d;
  logic [CW-1:0]      bestc_q, bestc_d;
  logic [LBL_W-1:0]   label_q;
  logic [CW-1:0]      votes_q;
  logic               lbl_err_q;

  logic               start_ok;
  logic [SW-1:0]      k_clamp;
  logic               lbl_valid;
  logic [CW-1:0]      cnt_c;
  logic               take;

`ifdef KNN_VOTER_NEAREST_TIE_EN
  logic [SW-1:0]      p_q;
  logic [SW-1:0]      first_q [NCLASS];
  logic [SW-1:0]      first_c, first_best;
`endif

  assign start_ok  = (state_q == S_IDLE) && start_i;
  assign k_clamp   = (k_i > SW'(HW_K)) ? SW'(HW_K) : k_i;
  assign lbl_valid = 32'(lbl_data_i) < 32'(NCLASS);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    sel_o      = '0;
    lbl_addr_o = '0;
    lbl_rd_o   = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (k_clamp != '0) ? S_FETCH : S_DRAIN;
      end
      S_FETCH: begin
        sel_o      = s_q;
        lbl_addr_o = idx_in_i;
        lbl_rd_o   = 1'b1;
        if (s_q == kk_q - SW'(1)) state_d = S_DRAIN;
      end
      S_DRAIN:  state_d = S_ARGMAX;
      S_ARGMAX: begin
        if (c_q == LBL_W'(NCLASS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Argmax step: class 0 seeds the running best, later classes must beat it.
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < NCLASS; i++) begin
      if (c_q == LBL_W'(i)) cnt_c = cnt_q[i];
    end
`ifdef KNN_VOTER_NEAREST_TIE_EN
    first_c    = '1;
    first_best = '1;
    for (int i = 0; i < NCLASS; i++) begin
      if (c_q == LBL_W'(i))    first_c    = first_q[i];
      if (best_q == LBL_W'(i)) first_best = first_q[i];
    end
    take = (c_q == '0) || (cnt_c > bestc_q) ||
           ((cnt_c == bestc_q) && (cnt_c != '0) && (first_c < first_best));
`else
    take = (c_q == '0) || (cnt_c > bestc_q);
`endif
    best_d  = take ? c_q   : best_q;
    bestc_d = take ? cnt_c : bestc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kk_q      <= '0;
      s_q       <= '0;
      rd_q      <= 1'b0;
      c_q       <= '0;
      best_q    <= '0;
      bestc_q   <= '0;
      label_q   <= '0;
      votes_q   <= '0;
      lbl_err_q <= 1'b0;
      for (int i = 0; i < NCLASS; i++) cnt_q[i] <= '0;
`ifdef KNN_VOTER_NEAREST_TIE_EN
      p_q <= '0;
      for (int i = 0; i < NCLASS; i++) first_q[i] <= '0;
`endif
    end else begin
      rd_q <= lbl_rd_o;
      if (start_ok) begin
        kk_q      <= k_clamp;
        s_q       <= '0;
        c_q       <= '0;
        best_q    <= '0;
        bestc_q   <= '0;
        label_q   <= '0;
        votes_q   <= '0;
        lbl_err_q <= 1'b0;
        for (int i = 0; i < NCLASS; i++) cnt_q[i] <= '0;
`ifdef KNN_VOTER_NEAREST_TIE_EN
        for (int i = 0; i < NCLASS; i++) first_q[i] <= '1;
`endif
      end else begin
        if (state_q == S_FETCH) begin
          s_q <= s_q + SW'(1);
`ifdef KNN_VOTER_NEAREST_TIE_EN
          p_q <= s_q;
`endif
        end
        if (rd_q) begin
          if (lbl_valid) begin
            for (int i = 0; i < NCLASS; i++) begin
              if (lbl_data_i == LBL_W'(i)) begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
`ifdef KNN_VOTER_NEAREST_TIE_EN
                if (first_q[i] == '1) first_q[i] <= p_q;
`endif
              end
            end
          end else begin
            lbl_err_q <= 1'b1;
          end
        end
        if (state_q == S_ARGMAX) begin
          c_q     <= c_q + LBL_W'(1);
          best_q  <= best_d;
          bestc_q <= bestc_d;
          if (c_q == LBL_W'(NCLASS - 1)) begin
            label_q <= best_d;
            votes_q <= bestc_d;
          end
        end
      end
    end
  end

  assign label_o   = label_q;
  assign votes_o   = votes_q;
  assign lbl_err_o = lbl_err_q;

endmodule

`default_nettype wire

// File: tb/tb_knn_voter.sv
// +---------------------------------------------------------------------------+
// | tb_knn_voter: directed scoreboard bench for knn_voter (label memory model).|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_knn_voter;

  localparam int NCLASS = 10;
  localparam int LAT    = NCLASS + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k;
  logic [15:0] sel;
  logic [15:0] idx_in;
  logic [15:0] lbl_addr;
  logic        lbl_rd;
  logic [7:0]  lbl_data = 8'hFF;
  logic        busy;
  logic        done;
  logic [7:0]  label;
  logic [3:0]  votes;
  logic        lbl_err;

  knn_voter #(.W(32), .HW_K(10), .NCLASS(NCLASS), .LBL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .k_i        (k),
    .sel_o      (sel),
    .idx_in_i   (idx_in),
    .lbl_addr_o (lbl_addr),
    .lbl_rd_o   (lbl_rd),
    .lbl_data_i (lbl_data),
    .busy_o     (busy),
    .done_o     (done),
    .label_o    (label),
    .votes_o    (votes),
    .lbl_err_o  (lbl_err)
  );

  always #5 clk = ~clk;

  // Sorter stand-in maps slot s to neighbour index 100+s; label memory has 1-cycle latency.
  logic [7:0] mem [256];
  assign idx_in = sel + 16'd100;
  always @(posedge clk) lbl_data <= lbl_rd ? mem[lbl_addr[7:0]] : 8'hFF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] lbl;
    logic [3:0] votes;
    logic       err;
    int         cyc;
    int         kk;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int exp_sel = 0;
  int rd_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: read sequence and done results against the scoreboard.
  always @(negedge clk) begin
    if (!rst && lbl_rd) begin
      check("sel_seq", 64'(sel), 64'(exp_sel));
      check("lbl_addr", 64'(lbl_addr), 64'(exp_sel + 100));
      exp_sel++;
      rd_cnt++;
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("label", 64'(label), 64'(e.lbl));
        check("votes", 64'(votes), 64'(e.votes));
        check("lbl_err", 64'(lbl_err), 64'(e.err));
        check("read_count", 64'(rd_cnt), 64'(e.kk));
      end
    end
  end

  task automatic load(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    logic [7:0] p [10];
    p = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9};
    for (int i = 0; i < 10; i++) mem[100 + i] = p[i];
  endtask

  task automatic run(input int kin, input int kk, input logic [7:0] l,
                     input logic [3:0] v, input logic e);
    exp_t x;
    @(negedge clk);
    x.lbl = l; x.votes = v; x.err = e; x.cyc = cyc + kk + LAT; x.kk = kk;
    sb.push_back(x);
    exp_sel = 0;
    rd_cnt  = 0;
    start   = 1'b1;
    k       = 16'(kin);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_label"}, 64'(label), 64'd0);
    check({tag, "_votes"}, 64'(votes), 64'd0);
    check({tag, "_err"}, 64'(lbl_err), 64'd0);
    check({tag, "_rd"}, 64'(lbl_rd), 64'd0);
    check({tag, "_sel"}, 64'(sel), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    rst   = 1'b1;
    start = 1'b0;
    k     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Basic majority vote.
    load(8'd3, 8'd3, 8'd7, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run(5, 5, 8'd3, 4'd3, 1'b0);
    wait_done();

    // Tie between classes 2 and 6; class 6 has the nearest member.
    load(8'd6, 8'd2, 8'd2, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
`ifdef KNN_VOTER_NEAREST_TIE_EN
    run(4, 4, 8'd6, 4'd2, 1'b0);
`else
    run(4, 4, 8'd2, 4'd2, 1'b0);
`endif
    wait_done();

    // k clamped to 10, out-of-range label on slot 4 is not counted.
    load(8'd1, 8'd1, 8'd2, 8'd2, 8'd12, 8'd2, 8'd2, 8'd4, 8'd5, 8'd1);
    run(15, 10, 8'd2, 4'd4, 1'b1);
    wait_done();
    check("err_sticky", 64'(lbl_err), 64'd1);

    // k=0: no reads, error flag cleared by the new start.
    run(0, 0, 8'd0, 4'd0, 1'b0);
    check("err_cleared", 64'(lbl_err), 64'd0);
    wait_done();

    // Abort in FETCH slot 2.
    load(8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    exp_sel = 0;
    start   = 1'b1;
    k       = 16'd5;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!(lbl_rd && sel == 16'd2) && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("abort_reach_slot2", 64'(sel), 64'd2);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_done", 64'(done), 64'd0);

    // Restart, with an extra start pulsed while busy.
    load(8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run(3, 3, 8'd5, 4'd3, 1'b0);
    @(negedge clk);
    start = 1'b1;
    k     = 16'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/knn_voter.md
Name: knn_voter

Overview:
- Downstream consumer of the pipeline sorter. After the sorter's DONE, it walks the sorter's K sorted neighbour slots through SEL and reads each neighbour index from DATA_OUT.
- For each index it fetches that neighbour's class label from an external label memory with 1-cycle read latency.
- It accumulates per-class vote counts, runs an argmax and reports the winning class with a one-cycle done pulse.
- Occupies the vote stage of the k-NN accelerator, between the sorter and the software-visible register bank.

Parameters:
W, 32, datapath width; SEL and index ports are W/2 bits, matching the sorter.
HW_K, 10, maximum neighbours held by the sorter.
NCLASS, 10, number of label classes (2..256).
LBL_W, 8, label width; must satisfy 2^LBL_W >= NCLASS.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle pulse that starts a vote; ignored unless busy=0.
k  input  W/2  neighbours to vote on; clamped to HW_K; sampled on accepted start.
sel  output  W/2  slot select driven to the sorter's SEL.
idx_in  input  W/2  neighbour index from the sorter's DATA_OUT, combinational on sel.
lbl_addr  output  W/2  label memory address.
lbl_rd  output  1  label read strobe.
lbl_data  input  LBL_W  label returned exactly 1 cycle after lbl_rd.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse; label is valid from this cycle.
label  output  LBL_W  winning class; held until the next accepted start.
votes  output  clog2(HW_K+1)  vote count of the winning class, held with label.
lbl_err  output  1  sticky; set when any lbl_data >= NCLASS; cleared on accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Reset mid-operation aborts immediately:
  - no done pulse is produced;
  - the next cycle is IDLE with all outputs 0.
- State IDLE:
  - start=1: latch kk=min(k,HW_K), clear all NCLASS counts, clear first_pos[] to all-ones, clear lbl_err; go to FETCH if kk>0, else DRAIN.
  - start while busy=1 is ignored and has no effect.
- State FETCH: one read per cycle, slot counter s=0..kk-1.
  - sel=s, lbl_addr=idx_in, lbl_rd=1.
  - After s=kk-1 go to DRAIN.
  - sel and lbl_addr are 0 outside FETCH.
- Accumulate: every cycle where the previous cycle had lbl_rd=1, with slot p = s-1 delayed:
  - if lbl_data<NCLASS: count[lbl_data] += 1, and if first_pos[lbl_data] is all-ones, first_pos[lbl_data] = p;
  - else lbl_err=1 and no vote is counted.
- State DRAIN: one cycle; absorbs the final lbl_data; go to ARGMAX.
- State ARGMAX: NCLASS cycles; class index c runs 0..NCLASS-1 sequentially.
  - Running best starts at class 0.
  - Class c replaces best only if count[c] > best_count, or if a tie is won under the rule in Optional Feature.
  - After c=NCLASS-1 go to DONE.
- State DONE: drive label and votes, done=1 for one cycle, busy=0 next cycle; return to IDLE.
- Latency: done is asserted exactly kk+NCLASS+2 cycles after the start cycle.
  - kk=0: done after NCLASS+2 cycles, label=0, votes=0.
- Count width clog2(HW_K+1) cannot overflow, because kk<=HW_K.
- busy stays high through DONE and falls the cycle after.
- start arriving in the same cycle as done is ignored; start arriving the cycle after done is accepted.

Optional Feature:
Macro KNN_VOTER_NEAREST_TIE_EN.
- Defined: on equal counts (count>0), class c wins if first_pos[c] < first_pos[best], i.e. the class whose nearest member ranks closest wins.
- Undefined: ties keep the earlier (lower) class index; first_pos storage and its logic are not generated.
- All-zero counts give label 0 in both builds.

Test Plan:
- Reset then idle: rst held 3 cycles -> label=0, votes=0, done=0, busy=0, lbl_err=0.
- Basic vote: NCLASS=10, k=5, labels 3,3,7,3,1 -> done exactly 17 cycles after start, label=3, votes=3; lbl_rd high for exactly 5 cycles with sel=0..4.
- Tie: k=4, labels 6,2,2,6.
  - Macro undefined -> label=2, votes=2.
  - Macro defined -> label=6.
- Clamp and bad label:
  - k=15 (HW_K=10) -> exactly 10 reads with sel 0..9.
  - A lbl_data=12 on slot 4 -> lbl_err=1 and that slot contributes no vote.
  - A following start clears lbl_err.
- k=0 -> no lbl_rd, done 12 cycles after start, label=0, votes=0.
- Abort and restart:
  - rst asserted in FETCH slot 2 -> no done pulse, outputs 0.
  - A new start with k=3, labels 5,5,5 -> label=5, votes=3.
  - A start pulsed while busy is ignored: done count and timing are unchanged.
